compute_core_sequencer: RTL and testbench

- Queues 35-bit ComputeCore instructions from the host and issues them one at a time over the core's command_in / command_we0 interface.
- For each instruction it waits for done_ins_computation, then writes a NOP instruction (INS=0) to put the engine back in reset, and waits for done to deassert before issuing the next one.
- It also arbitrates the core's external BRAM port: the host gets the port only while no instruction is active.

---
 rtl/compute_core_sequencer_if.sv | 23 ++
 rtl/compute_core_sequencer.sv | 168 ++++++++++++++++
 tb/tb_compute_core_sequencer.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/compute_core_sequencer_if.sv
// Host push channel and ComputeCore command channel of the sequencer.
// The sequencer connects through the master modport; the host/core side uses slave.
interface compute_core_sequencer_if #(
  parameter int CMD_W = 35
);
  logic [CMD_W-1:0] cmd_in;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CMD_W-1:0] command_in;
  logic             command_we0;
  logic             command_we1;
  logic             done_ins_computation;

  modport master (
    input  cmd_in, cmd_valid, done_ins_computation,
    output cmd_ready, command_in, command_we0, command_we1
  );

  modport slave (
    output cmd_in, cmd_valid, done_ins_computation,
    input  cmd_ready, command_in, command_we0, command_we1
  );
endinterface

// File: rtl/compute_core_sequencer.sv
// Queues host instructions and issues them to ComputeCore one at a time, arbitrating its BRAM port.
// Optional macro SEQ_TIMEOUT_EN adds a sticky timeout on the done handshake.
module compute_core_sequencer #(
  parameter int DEPTH = 8,
  parameter int CMD_W = 35,
  parameter int TO_W  = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  compute_core_sequencer_if.master bus,
  output logic                     ext_grant,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [15:0]              done_count,
  output logic                     timeout_err
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, RELEASE, WAIT_CLR} state_t;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
    $error("DEPTH must be a power of two and at least 2");
  end
  if (TO_W < 2) begin : g_to_w_check
    $error("TO_W must be at least 2");
  end

  state_t           state, next_state;
  logic [CMD_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic [CMD_W-1:0] command_q, command_next;
  logic             we0_q, we0_next;
  logic             done_inc;
  logic             push, pop;

  assign bus.cmd_ready   = (count != (AW+1)'(DEPTH));
  assign push            = bus.cmd_valid && bus.cmd_ready;
  assign pop             = (state == IDLE) && (count != '0);
  assign bus.command_in  = command_q;
  assign bus.command_we0 = we0_q;
  assign bus.command_we1 = 1'b0;
  assign ext_grant       = (state == IDLE) && (count == '0);
  assign busy            = (count != '0) || (state != IDLE);
  assign fifo_count      = count;

`ifdef SEQ_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;
  logic            to_hit;
  logic            timeout_q;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.cmd_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      command_q  <= '0;
      we0_q      <= 1'b0;
      done_count <= '0;
    end else begin
      state     <= next_state;
      command_q <= command_next;
      we0_q     <= we0_next;
      if (done_inc) begin
        done_count <= done_count + 16'd1;
      end
    end
  end

  // Completion (or timeout) rewrites INS=0 so the core engines fall back into reset.
  always_comb begin
    next_state   = state;
    command_next = command_q;
    we0_next     = 1'b0;
    done_inc     = 1'b0;
`ifdef SEQ_TIMEOUT_EN
    to_hit       = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (count != '0) begin
          command_next = mem[rd_ptr];
          we0_next     = 1'b1;
          next_state   = ISSUE;
        end
      end
      ISSUE: next_state = WAIT_DONE;
      WAIT_DONE: begin
        if (bus.done_ins_computation) begin
          command_next = '0;
          we0_next     = 1'b1;
          done_inc     = 1'b1;
          next_state   = RELEASE;
        end
`ifdef SEQ_TIMEOUT_EN
        else if (to_cnt == '1) begin
          command_next = '0;
          we0_next     = 1'b1;
          to_hit       = 1'b1;
          next_state   = RELEASE;
        end
`endif
      end
      RELEASE: next_state = WAIT_CLR;
      WAIT_CLR: begin
        if (!bus.done_ins_computation) begin
          next_state = IDLE;
        end
`ifdef SEQ_TIMEOUT_EN
        else if (to_cnt == '1) begin
          to_hit     = 1'b1;
          next_state = IDLE;
        end
`endif
      end
      default: next_state = IDLE;
    endcase
  end

`ifdef SEQ_TIMEOUT_EN
  // The counter restarts on every entry to a wait state and runs only while staying there.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (to_hit) begin
        timeout_q <= 1'b1;
      end
      if (((state == WAIT_DONE) || (state == WAIT_CLR)) && (next_state == state)) begin
        to_cnt <= to_cnt + TO_W'(1);
      end else begin
        to_cnt <= '0;
      end
    end
  end

  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_compute_core_sequencer.sv
// Directed self-checking bench for compute_core_sequencer.
// Define SEQ_TIMEOUT_EN to also run the timeout scenario (TO_W=4).
module tb_compute_core_sequencer;
  localparam int DEPTH = 8;
  localparam int CMD_W = 35;
`ifdef SEQ_TIMEOUT_EN
  localparam int TO_W = 4;
`else
  localparam int TO_W = 20;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ext_grant;
  logic        busy;
  logic [3:0]  fifo_count;
  logic [15:0] done_count;
  logic        timeout_err;

  int assertions = 0;
  int failures   = 0;
  logic [CMD_W-1:0] issued [$];

  compute_core_sequencer_if #(.CMD_W(CMD_W)) bus ();

  compute_core_sequencer #(.DEPTH(DEPTH), .CMD_W(CMD_W), .TO_W(TO_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .ext_grant   (ext_grant),
    .busy        (busy),
    .fifo_count  (fifo_count),
    .done_count  (done_count),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // Every non-NOP command write is logged so issue order can be checked.
  always @(negedge clk) begin
    if (rst && bus.command_we0 && (bus.command_in != '0)) begin
      issued.push_back(bus.command_in);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.cmd_valid = 1'b0;
    bus.cmd_in = '0;
    bus.done_ins_computation = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    issued.delete();
  endtask

  task automatic wait_issue(output bit timed_out);
    int n = 0;
    while (!(bus.command_we0 && (bus.command_in != '0)) && (n < 40)) begin
      tick();
      n++;
    end
    timed_out = !(bus.command_we0 && (bus.command_in != '0));
  endtask

  task automatic wait_nop(output bit timed_out);
    int n = 0;
    while (!(bus.command_we0 && (bus.command_in == '0)) && (n < 40)) begin
      tick();
      n++;
    end
    timed_out = !(bus.command_we0 && (bus.command_in == '0));
  endtask

  function automatic logic [CMD_W-1:0] entry(int i);
    entry = {10'(i), 10'(2 * i), 10'(3 * i + 1), 5'(i + 1)};
  endfunction

  task automatic test_reset();
    int pulses = 0;
    bus.cmd_valid = 1'b0;
    bus.cmd_in = '0;
    bus.done_ins_computation = 1'b0;
    rst = 1'b0;
    tick();
    assertions++;
    if ({bus.command_in, bus.command_we0, bus.command_we1} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_cmd: got %0h we0=%0b we1=%0b, expected 0", bus.command_in, bus.command_we0, bus.command_we1);
    end
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.command_we0) pulses++;
    end
    assertions++;
    if (pulses != 0) begin
      failures++;
      $display("[TB] FAIL idle_we0_pulses: got %0d, expected 0", pulses);
    end
    assertions++;
    if ({bus.cmd_ready, ext_grant, busy} !== 3'b110) begin
      failures++;
      $display("[TB] FAIL idle_flags: got ready/grant/busy=%b, expected 110", {bus.cmd_ready, ext_grant, busy});
    end
    assertions++;
    if ({fifo_count, done_count, timeout_err} !== '0) begin
      failures++;
      $display("[TB] FAIL idle_counts: got fifo=%0d done=%0d to=%0b, expected all 0", fifo_count, done_count, timeout_err);
    end
  endtask

  task automatic test_single();
    bit to;
    do_reset();
    bus.cmd_in = 35'h18;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    assertions++;
    if (ext_grant !== 1'b0 || fifo_count !== 4'd1) begin
      failures++;
      $display("[TB] FAIL single_pop_cycle: got grant=%0b fifo=%0d, expected grant=0 fifo=1", ext_grant, fifo_count);
    end
    wait_issue(to);
    assertions++;
    if (to || bus.command_in !== 35'h18) begin
      failures++;
      $display("[TB] FAIL single_issue: got %0h timeout=%0b, expected 18", bus.command_in, to);
    end
    tick();
    assertions++;
    if (bus.command_we0 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_we0_width: got we0=%0b, expected 0", bus.command_we0);
    end
    repeat (19) tick();
    bus.done_ins_computation = 1'b1;
    tick();
    assertions++;
    if (bus.command_we0 !== 1'b1 || bus.command_in !== '0) begin
      failures++;
      $display("[TB] FAIL single_nop_write: got we0=%0b cmd=%0h, expected we0=1 cmd=0", bus.command_we0, bus.command_in);
    end
    assertions++;
    if (done_count !== 16'd1) begin
      failures++;
      $display("[TB] FAIL single_done_count: got %0d, expected 1", done_count);
    end
    tick();
    assertions++;
    if (bus.command_we0 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_nop_width: got we0=%0b, expected 0", bus.command_we0);
    end
    repeat (2) tick();
    assertions++;
    if (ext_grant !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_grant_held: got %0b, expected 0 while done high", ext_grant);
    end
    bus.done_ins_computation = 1'b0;
    tick();
    assertions++;
    if (ext_grant !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_grant_back: got grant=%0b busy=%0b, expected 1/0", ext_grant, busy);
    end
  endtask

  task automatic test_fifo_full();
    bit to;
    int timeouts = 0;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      bus.cmd_in = entry(i);
      bus.cmd_valid = 1'b1;
      tick();
    end
    bus.cmd_in = 35'h7_FFFF_FFFF;
    assertions++;
    if (bus.cmd_ready !== 1'b0 || fifo_count !== 4'd8) begin
      failures++;
      $display("[TB] FAIL full_ready: got ready=%0b fifo=%0d, expected 0/8", bus.cmd_ready, fifo_count);
    end
    tick();
    bus.cmd_valid = 1'b0;
    assertions++;
    if (fifo_count !== 4'd8) begin
      failures++;
      $display("[TB] FAIL full_drop: got fifo=%0d, expected 8", fifo_count);
    end
    for (int k = 0; k < 9; k++) begin
      bus.done_ins_computation = 1'b1;
      wait_nop(to);
      if (to) timeouts++;
      bus.done_ins_computation = 1'b0;
      if (k < 8) begin
        wait_issue(to);
        if (to) timeouts++;
      end
    end
    repeat (3) tick();
    assertions++;
    if (timeouts != 0) begin
      failures++;
      $display("[TB] FAIL full_handshake: got %0d expired waits, expected 0", timeouts);
    end
    assertions++;
    if (done_count !== 16'd9 || fifo_count !== 4'd0 || ext_grant !== 1'b1) begin
      failures++;
      $display("[TB] FAIL full_drain: got done=%0d fifo=%0d grant=%0b, expected 9/0/1", done_count, fifo_count, ext_grant);
    end
    assertions++;
    if (issued.size() != 9) begin
      failures++;
      $display("[TB] FAIL full_issue_count: got %0d, expected 9", issued.size());
    end
    for (int i = 0; i < 9 && i < issued.size(); i++) begin
      assertions++;
      if (issued[i] !== entry(i)) begin
        failures++;
        $display("[TB] FAIL full_order[%0d]: got %0h, expected %0h", i, issued[i], entry(i));
      end
    end
  endtask

  task automatic test_simultaneous();
    bit to;
    do_reset();
    bus.cmd_in = 35'h1_2345_6781;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_in = 35'h2_0000_0A05;
    tick();
    bus.cmd_valid = 1'b0;
    assertions++;
    if (fifo_count !== 4'd1 || bus.command_in !== 35'h1_2345_6781 || bus.command_we0 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL simul_push_pop: got fifo=%0d cmd=%0h we0=%0b, expected 1/123456781/1", fifo_count, bus.command_in, bus.command_we0);
    end
    bus.done_ins_computation = 1'b1;
    wait_nop(to);
    bus.done_ins_computation = 1'b0;
    wait_issue(to);
    assertions++;
    if (to || bus.command_in !== 35'h2_0000_0A05 || fifo_count !== 4'd0) begin
      failures++;
      $display("[TB] FAIL simul_second: got cmd=%0h fifo=%0d timeout=%0b, expected 200000a05/0", bus.command_in, fifo_count, to);
    end
    bus.done_ins_computation = 1'b1;
    wait_nop(to);
    bus.done_ins_computation = 1'b0;
    repeat (3) tick();
    assertions++;
    if (done_count !== 16'd2 || ext_grant !== 1'b1) begin
      failures++;
      $display("[TB] FAIL simul_done: got done=%0d grant=%0b, expected 2/1", done_count, ext_grant);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.cmd_valid = 1'b1;
    bus.cmd_in = 35'h0_0000_0C03;
    tick();
    bus.cmd_in = 35'h0_0000_0D04;
    tick();
    bus.cmd_in = 35'h0_0000_0E05;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    assertions++;
    if (bus.command_in !== 35'h0_0000_0C03 || fifo_count !== 4'd2) begin
      failures++;
      $display("[TB] FAIL areset_setup: got cmd=%0h fifo=%0d, expected c03/2", bus.command_in, fifo_count);
    end
    #2;
    rst = 1'b0;
    #1;
    assertions++;
    if (bus.command_in !== '0 || bus.command_we0 !== 1'b0 || fifo_count !== 4'd0) begin
      failures++;
      $display("[TB] FAIL areset_immediate: got cmd=%0h we0=%0b fifo=%0d, expected 0/0/0", bus.command_in, bus.command_we0, fifo_count);
    end
    assertions++;
    if (ext_grant !== 1'b1 || busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL areset_flags: got grant=%0b busy=%0b ready=%0b, expected 1/0/1", ext_grant, busy, bus.cmd_ready);
    end
    tick();
    rst = 1'b1;
    tick();
  endtask

`ifdef SEQ_TIMEOUT_EN
  task automatic test_timeout();
    bit to;
    int n = 0;
    do_reset();
    bus.cmd_in = 35'h0_0000_0019;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    wait_issue(to);
    while (!timeout_err && n < 40) begin
      tick();
      n++;
    end
    assertions++;
    if (timeout_err !== 1'b1 || bus.command_we0 !== 1'b1 || bus.command_in !== '0) begin
      failures++;
      $display("[TB] FAIL timeout_nop: got err=%0b we0=%0b cmd=%0h, expected 1/1/0", timeout_err, bus.command_we0, bus.command_in);
    end
    assertions++;
    if (n != 17) begin
      failures++;
      $display("[TB] FAIL timeout_latency: got %0d cycles after issue, expected 17", n);
    end
    repeat (3) tick();
    assertions++;
    if (done_count !== 16'd0 || ext_grant !== 1'b1 || timeout_err !== 1'b1) begin
      failures++;
      $display("[TB] FAIL timeout_idle: got done=%0d grant=%0b err=%0b, expected 0/1/1", done_count, ext_grant, timeout_err);
    end
  endtask
`endif

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_in = '0;
    bus.done_ins_computation = 1'b0;
    $display("[TB] compute_core_sequencer bench starting");
    test_reset();
    test_single();
    test_fifo_full();
    test_simultaneous();
    test_async_reset();
`ifdef SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end
endmodule
